// File: rtl/turn_signal_conditioner_if.sv
// turn_signal_conditioner_if
// Signal bundle between the raw stalk/hazard switches, the conditioner and
// the tail-light sequencer. The master side drives the raw switch levels and
// observes the clean requests; the slave side is the conditioner itself.
`timescale 1ns/1ps

interface turn_signal_conditioner_if;
    logic Lraw;
    logic Rraw;
    logic Hraw;
    logic L;
    logic R;
    logic Haz;
    logic Tick;

    modport master (
        output Lraw,
        output Rraw,
        output Hraw,
        input  L,
        input  R,
        input  Haz,
        input  Tick
    );

    modport slave (
        input  Lraw,
        input  Rraw,
        input  Hraw,
        output L,
        output R,
        output Haz,
        output Tick
    );
endinterface

// File: rtl/turn_signal_conditioner.sv
// turn_signal_conditioner
// Input stage for the Thunderbird tail-light sequencer. Synchronizes and
// debounces the raw left, right and hazard switch levels, merges hazard into
// the clean L/R requests and produces a free-running Tick step enable.
//
// Optional build macro: HAZARD_LATCH_EN
//   defined   - the hazard switch is a push-button; each debounced press
//               toggles the hazard state.
//   undefined - the hazard state simply follows the debounced hazard level.
`timescale 1ns/1ps

module turn_signal_conditioner #(
    parameter int DEB_CYCLES = 4,
    parameter int TICK_DIV   = 4
) (
    input  logic                       Clk,
    input  logic                       Rs,
    turn_signal_conditioner_if.slave   io
);

    // Debounce counter must be able to hold DEB_CYCLES-1 with headroom.
    localparam int CW = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    // Prescaler width; TICK_DIV is at least 2 so this is never zero.
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    // Bit positions of the three switches in the packed vectors below.
    localparam int IDX_L = 0;
    localparam int IDX_R = 1;
    localparam int IDX_H = 2;

    logic [2:0]    raw_vec;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    deb_level;
    logic [2:0]    deb_level_next;
    logic [CW-1:0] deb_cnt      [3];
    logic [CW-1:0] deb_cnt_next [3];
    logic [TW-1:0] tick_cnt;
    logic          hz_state;

    assign raw_vec = {io.Hraw, io.Rraw, io.Lraw};

    // Two-flop synchronizer so nothing downstream ever sees a raw pin.
    always_ff @(posedge Clk or posedge Rs) begin
        if (Rs) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_vec;
            sync2 <= sync1;
        end
    end

    // Per-input debounce: count consecutive disagreements, adopt the new level
    // on the edge where the count would reach DEB_CYCLES, clear on agreement.
    always_comb begin
        deb_level_next = deb_level;
        for (int i = 0; i < 3; i++) begin
            deb_cnt_next[i] = '0;
            if (sync2[i] != deb_level[i]) begin
                if (deb_cnt[i] == DEB_LAST) begin
                    deb_level_next[i] = sync2[i];
                end else begin
                    deb_cnt_next[i] = deb_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Debounced levels and their counters; reset discards partial counts.
    always_ff @(posedge Clk or posedge Rs) begin
        if (Rs) begin
            deb_level <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            deb_level <= deb_level_next;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= deb_cnt_next[i];
            end
        end
    end

`ifdef HAZARD_LATCH_EN
    typedef enum logic {
        HZ_OFF = 1'b0,
        HZ_ON  = 1'b1
    } hz_state_t;

    hz_state_t hz_cur;
    hz_state_t hz_nxt;
    logic      hz_press;

    // A press is the edge on which the debounced hazard level rises, so the
    // toggle lands on the same edge as the debounced level changes.
    assign hz_press = deb_level_next[IDX_H] & ~deb_level[IDX_H];

    // Hazard toggle register.
    always_ff @(posedge Clk or posedge Rs) begin
        if (Rs) begin
            hz_cur <= HZ_OFF;
        end else begin
            hz_cur <= hz_nxt;
        end
    end

    // Flip state once per press; holding or releasing the button does nothing.
    always_comb begin
        hz_nxt = hz_cur;
        if (hz_press) begin
            case (hz_cur)
                HZ_OFF:  hz_nxt = HZ_ON;
                HZ_ON:   hz_nxt = HZ_OFF;
                default: hz_nxt = HZ_OFF;
            endcase
        end
    end

    assign hz_state = (hz_cur == HZ_ON);
`else
    // Level mode: hazard is active exactly while the debounced switch is on.
    assign hz_state = deb_level[IDX_H];
`endif

    // Free-running prescaler, 0..TICK_DIV-1, independent of switch activity.
    always_ff @(posedge Clk or posedge Rs) begin
        if (Rs) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Outputs come only from registers. Both stalks on without hazard gives
    // L=R=1 with Haz=0; the sequencer decides what that means.
    assign io.L    = deb_level[IDX_L] | hz_state;
    assign io.R    = deb_level[IDX_R] | hz_state;
    assign io.Haz  = hz_state;
    assign io.Tick = (tick_cnt == TICK_LAST);

endmodule
